multi_cycle_adder: RTL and testbench

Parametrised, chunk-serial successor to the 4-bit ripple full adder. It latches a WIDTH-bit operand pair on a start pulse and adds CHUNK bits per clock through a registered carry. It then presents sum, carry-out and signed overflow with a one-cycle done pulse. The block sits wherever a wide add is needed but a full-width ripple chain is too long for one clock period. It trades WIDTH/CHUNK cycles of latency for a CHUNK-bit critical path.

---
 rtl/multi_cycle_adder.sv | 137 +++++++++++++
 tb/tb_multi_cycle_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_adder.sv
// multi_cycle_adder: chunk-serial WIDTH-bit adder. Latches an operand pair on
// start, adds CHUNK bits per clock through a registered carry, then pulses done
// with s/cout/ovf valid. K = WIDTH/CHUNK cycles of latency per operation.
// Optional feature macro: SUBTRACT_EN (when defined, sub=1 computes a - b).
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int K     = WIDTH / CHUNK;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [31:0]      chunk_base;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             accept;
  logic             last_chunk;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;

`ifdef SUBTRACT_EN
  // Subtraction is a + ~b + 1; the forced carry-in overrides cin.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  // Without subtract support the B path is a plain wire and sub is dropped.
  logic sub_unused;
  assign sub_unused = sub;
  assign b_eff      = b;
  assign cin_eff    = cin;
`endif

  // Bit offset of the chunk currently being processed.
  assign chunk_base = 32'(idx) * CHUNK;
  assign a_chunk    = CHUNK'(a_lat >> chunk_base);
  assign b_chunk    = CHUNK'(b_lat >> chunk_base);
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  assign last_chunk = (idx == IDX_W'(K - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and the per-chunk add; results persist until overwritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat <= '0;
      b_lat <= '0;
      carry <= 1'b0;
      idx   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_lat <= a;
      b_lat <= b_eff;
      carry <= cin_eff;
      idx   <= '0;
    end else if (state == RUN) begin
      s[chunk_base +: CHUNK] <= chunk_sum[CHUNK-1:0];
      carry                  <= chunk_sum[CHUNK];
      if (last_chunk) begin
        idx  <= '0;
        cout <= chunk_sum[CHUNK];
        // Top bit of the final chunk is s[WIDTH-1]; same-sign inputs giving
        // a differently-signed result is a two's-complement overflow.
        ovf  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) &&
                (chunk_sum[CHUNK-1] != a_lat[WIDTH-1]);
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Testbench for multi_cycle_adder: a 16/4 instance and an 8/8 instance,
// directed and random operations checked against an integer arithmetic model.
module tb_multi_cycle_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        busy, done, cout, ovf;
  logic [15:0] s;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8, sub8;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  s8;

  int checks = 0;
  int errors = 0;

`ifdef SUBTRACT_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .s(s), .cout(cout), .ovf(ovf)
  );

  multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                input logic mcin, input logic msub,
                                output logic [31:0] ms, output logic mcout, output logic mov);
    longint lim, ua, ub, sa, sb, full, r;
    lim = longint'(1) << (w - 1);
    ua  = longint'(ma);
    ub  = longint'(mb);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (SUB_EN && msub) begin
      full  = ua - ub;
      mcout = (ua >= ub);
      r     = sa - sb;
    end else begin
      full  = ua + ub + longint'(mcin);
      mcout = (full >= 2 * lim);
      r     = sa + sb + longint'(mcin);
    end
    ms  = 32'(full & (2 * lim - 1));
    mov = (r >= lim) || (r < -lim);
  endfunction

  // One 16-bit operation with exact cycle-by-cycle timing checks.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input logic tcin, input logic tsub);
    logic [31:0] es;
    logic ec, eo;
    model(16, {16'b0, ta}, {16'b0, tb}, tcin, tsub, es, ec, eo);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tcin; sub = tsub;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("sum", 32'(s), es);
    chk("cout", 32'(cout), 32'(ec));
    chk("ovf", 32'(ovf), 32'(eo));
    $display("op16 a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d (exp s=%h cout=%0d ovf=%0d)",
             ta, tb, tcin, tsub, s, cout, ovf, es[15:0], ec, eo);
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tcin, input logic tsub);
    logic [31:0] es;
    logic ec, eo;
    model(8, {24'b0, ta}, {24'b0, tb}, tcin, tsub, es, ec, eo);
    @(negedge clk);
    start8 = 1'b1; a8 = ta; b8 = tb; cin8 = tcin; sub8 = tsub;
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    @(negedge clk);
    chk("busy8_run", 32'(busy8), 32'd1);
    chk("done8_early", 32'(done8), 32'd0);
    @(negedge clk);
    chk("done8_pulse", 32'(done8), 32'd1);
    chk("sum8", 32'(s8), es);
    chk("cout8", 32'(cout8), 32'(ec));
    chk("ovf8", 32'(ovf8), 32'(eo));
    $display("op8 a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d (exp s=%h)",
             ta, tb, tcin, tsub, s8, cout8, ovf8, es[7:0]);
    @(negedge clk);
    chk("done8_once", 32'(done8), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_s8", 32'(s8), 32'd0);
    reset = 1'b0;

    // Directed cases.
    op16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op16(16'h0005, 16'h0007, 1'b0, 1'b1);
    op16(16'h8000, 16'h8000, 1'b1, 1'b0);

    // Start held high through RUN and DONE: only one result, next accept at T+K+2.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    a = 16'hFFFF; b = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("ign_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum", 32'(s), 32'h2345);
    chk("ign_cout", 32'(cout), 32'd0);
    chk("ign_ovf", 32'(ovf), 32'd0);
    $display("held-start a=1234 b=1111 -> s=%h cout=%0d ovf=%0d", s, cout, ovf);
    @(negedge clk);
    chk("ign_idle_busy", 32'(busy), 32'd0);
    chk("ign_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(negedge clk);
    chk("reaccept_done", 32'(done), 32'd1);
    chk("reaccept_sum", 32'(s), 32'hFFFE);
    chk("reaccept_cout", 32'(cout), 32'd1);
    $display("re-accept a=ffff b=ffff -> s=%h cout=%0d ovf=%0d", s, cout, ovf);
    @(negedge clk);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    @(negedge clk);
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_s", 32'(s), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    $display("abort reset mid-RUN -> busy=%0d done=%0d s=%h", busy, done, s);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    op16(16'hAAAA, 16'h5555, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001;
    @(negedge clk);
    chk("rst_wins_busy", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_wins_idle", 32'(busy), 32'd0);

    // Random operations, back to back.
    for (int n = 0; n < 20; n++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    // Single-chunk instance.
    op8(8'h80, 8'h80, 1'b1, 1'b0);
    chk("k1_sum_const", 32'(s8), 32'h01);
    for (int n = 0; n < 6; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
